// File: rtl/shift_add_mult_16x16_if.sv
// rtl/shift_add_mult_16x16_if.sv - request/result bundle for the 16x16 shift-add multiplier
//
// Purpose: groups the start/operand request and the busy/done/product result of
//          shift_add_mult_16x16 so that both sides bind through modports.
// Signals:
//   start    master->slave  1   request to begin a multiply
//   a        master->slave  16  multiplicand, unsigned
//   b        master->slave  16  multiplier, unsigned
//   busy     slave->master  1   multiply in progress
//   done     slave->master  1   one-cycle completion pulse
//   product  slave->master  32  product of the last completed multiply
interface shift_add_mult_16x16_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/shift_add_mult_16x16.sv
// rtl/shift_add_mult_16x16.sv - sequential 16x16 unsigned shift-and-add multiplier
//
// Purpose: multiplies two 16-bit unsigned operands in a fixed 16-cycle CALC phase,
//          accumulating partial products through a single 32-bit ripple-carry adder.
// Ports (shift_add_mult_16x16):
//   clk    in   1   sole clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   bus    slave modport of shift_add_mult_16x16_if (start/a/b in, busy/done/product out)
// Ports (rca_32bit):
//   in1, in2  in   32  addends
//   cin       in   1   carry in
//   sum       out  32  in1 + in2 + cin, low 32 bits
//   cout      out  1   carry out of bit 31

module rca_32bit (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  // Explicit bit-serial carry chain; carry is a procedural local so the chain
  // stays a single combinational evaluation.
  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < 32; i++) begin
      sum[i] = in1[i] ^ in2[i] ^ carry;
      carry  = (in1[i] & in2[i]) | (in1[i] & carry) | (in2[i] & carry);
    end
    cout = carry;
  end
endmodule

module shift_add_mult_16x16 (
  input  logic                   clk,
  input  logic                   rst_n,
  shift_add_mult_16x16_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] mcand_q;
  logic [15:0] mplier_q;
  logic [31:0] acc_q;
  logic [3:0]  count_q;
  logic [31:0] product_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] adder_sum;
  logic        adder_cout;
  logic [31:0] acc_d;

  // cout cannot be 1 during CALC since every partial sum fits in 32 bits;
  // outside CALC the adder output is not consumed.
  rca_32bit u_adder (
    .in1  (acc_q),
    .in2  (mcand_q),
    .cin  (1'b0),
    .sum  (adder_sum),
    .cout (adder_cout)
  );

  // Accumulate only when the current multiplier bit is set.
  assign acc_d = mplier_q[0] ? adder_sum : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand_q  <= {16'b0, bus.a};
            mplier_q <= bus.b;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          // Fixed 16 iterations regardless of operand values.
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[30:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[15:1]};
          count_q  <= count_q + 4'd1;
          if (count_q == 4'd15) begin
            product_q <= acc_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_mult_16x16.sv
// tb/tb_shift_add_mult_16x16.sv - scoreboard bench for shift_add_mult_16x16
module tb_shift_add_mult_16x16;
  logic clk;
  logic rst_n;

  shift_add_mult_16x16_if bus ();

  shift_add_mult_16x16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1..16 CALC cycles, 17 DONE.
  logic [31:0] sb_q[$];
  int          m_phase;
  logic [31:0] exp_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      sb_q.delete();
    end else begin
      if (m_phase == 0) begin
        if (bus.start) begin
          sb_q.push_back(32'(bus.a) * 32'(bus.b));
          m_phase <= 1;
        end
      end else if (m_phase <= 16) begin
        m_phase <= m_phase + 1;
      end else begin
        m_phase <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) exp_last = '0;
    check_eq("busy", 32'(bus.busy), 32'(m_phase >= 1 && m_phase <= 16));
    check_eq("done", 32'(bus.done), 32'(m_phase == 17));
    if (m_phase == 17) begin
      if (sb_q.size() == 0) check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
      else exp_last = sb_q.pop_front();
    end
    check_eq("product", bus.product, exp_last);
    if (m_phase >= 1 && m_phase <= 16) check_eq("cout", 32'(dut.adder_cout), 32'd0);
  end

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv);
    int lat;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (bus.done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check_eq("latency", 32'(lat), 32'd16);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_product", bus.product, 32'd0);
    rst_n = 1'b1;

    run_op(16'h0003, 16'h0005);
    check_eq("basic_3x5", bus.product, 32'h0000_000F);
    run_op(16'hFFFF, 16'hFFFF);
    check_eq("max", bus.product, 32'hFFFE_0001);
    run_op(16'h1234, 16'h0000);
    check_eq("zero_b", bus.product, 32'h0);
    run_op(16'h0000, 16'hFFFF);
    check_eq("zero_a", bus.product, 32'h0);
    run_op(16'h8000, 16'h8000);
    check_eq("msb", bus.product, 32'h4000_0000);

    // Abort in the 7th CALC cycle; product was 0x40000000 before the reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h00FF;
    bus.b     = 16'h00FF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_product", bus.product, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run_op(16'h0003, 16'h0005);
    check_eq("post_abort_3x5", bus.product, 32'h0000_000F);

    // start held high with operands changing every cycle.
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 18 * 5; i++) begin
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      run_op(16'($urandom), 16'($urandom));
    end
    repeat (4) @(negedge clk);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
